// File: rtl/pll_lock_supervisor_pkg.sv
// pll_sup_pkg: state type, default parameters and saturation limits shared by the supervisor
package pll_sup_pkg;
    typedef enum logic [2:0] {WAIT_LOCK, STABLE, MEASURE, RUN, FAULT} state_t;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_REF_WINDOW = 16;
    localparam int DEF_RATIO = 18;
    localparam int DEF_TOL = 4;
    localparam int DEF_CNT_W = 16;
    localparam logic [7:0] LOSS_MAX = 8'hff;
    function automatic int expected(input int ratio, input int window);
        return ratio * window;
    endfunction
    localparam int EXPECTED = expected(DEF_RATIO, DEF_REF_WINDOW);
endpackage

// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: lock/reference inputs and qualified reset/diagnostic outputs
interface pll_lock_supervisor_if import pll_sup_pkg::*; #(
    parameter int CNT_W = DEF_CNT_W
);
    logic pll_locked;
    logic ref_clk_sample;
    logic rst_out;
    logic ready;
    logic freq_ok;
    logic [CNT_W-1:0] freq_count;
    logic lock_lost;
    logic [7:0] lock_loss_count;
    modport master (
        output pll_locked, ref_clk_sample,
        input rst_out, ready, freq_ok, freq_count, lock_lost, lock_loss_count
    );
    modport slave (
        input pll_locked, ref_clk_sample,
        output rst_out, ready, freq_ok, freq_count, lock_lost, lock_loss_count
    );
endinterface

// File: rtl/pll_lock_supervisor_ref_freq_meter.sv
// ref_freq_meter: counts core cycles across REF_WINDOW reference periods and grades the result
module ref_freq_meter import pll_sup_pkg::*; #(
    parameter int REF_WINDOW = DEF_REF_WINDOW,
    parameter int RATIO = DEF_RATIO,
    parameter int TOL = DEF_TOL,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic clock,
    input logic reset,
    input logic enable,
    input logic ref_clk_sample,
    output logic done,
    output logic pass,
    output logic [CNT_W-1:0] count
);
    localparam int EW = $clog2(REF_WINDOW + 1);
    localparam logic [EW-1:0] LAST = EW'(REF_WINDOW - 1);
    localparam logic [CNT_W-1:0] EXP = CNT_W'(expected(RATIO, REF_WINDOW));
    localparam logic [CNT_W-1:0] TOL_V = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    if (64'(RATIO) * 64'(REF_WINDOW) + 64'(TOL) > (64'd1 << CNT_W) - 64'd1) begin : g_fit
        $error("RATIO*REF_WINDOW+TOL does not fit in CNT_W bits");
    end
    logic [2:0] sync;
    logic open, ref_rise, close_edge;
    logic [CNT_W-1:0] cnt, dev;
    logic [EW-1:0] edges;
    assign ref_rise = sync[1] & ~sync[2];
    assign close_edge = ref_rise && edges == LAST;
    // the window closes before cnt can wrap, so cnt+1 never overflows while open
    assign count = cnt + 1'b1;
    assign done = enable && open && (close_edge || count == CNT_MAX);
    assign dev = count >= EXP ? count - EXP : EXP - count;
    assign pass = dev <= TOL_V && count != CNT_MAX;
    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '0;
            open <= 1'b0;
            cnt <= '0;
            edges <= '0;
        end else begin
            sync <= {sync[1:0], ref_clk_sample};
            if (!enable) begin
                open <= 1'b0;
                cnt <= '0;
                edges <= '0;
            end else if (!open || done) begin
                open <= open ? close_edge : ref_rise;
                cnt <= '0;
                edges <= '0;
            end else begin
                cnt <= count;
                edges <= edges + EW'(ref_rise);
            end
        end
    end
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: qualifies PLL lock by stability and measured frequency, then releases
// a synchronous reset and ready flag; tracks lock-loss diagnostics.
module pll_lock_supervisor import pll_sup_pkg::*; #(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REF_WINDOW = DEF_REF_WINDOW,
    parameter int RATIO = DEF_RATIO,
    parameter int TOL = DEF_TOL,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic clock,
    input logic reset,
    pll_lock_supervisor_if.slave bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    state_t state;
    logic lk_m, lk_s, active, done, pass;
    logic [SW-1:0] stab;
    logic [CNT_W-1:0] count;
    assign active = state == MEASURE || state == RUN || state == FAULT;
    ref_freq_meter #(
        .REF_WINDOW(REF_WINDOW), .RATIO(RATIO), .TOL(TOL), .CNT_W(CNT_W)
    ) u_meter (
        .clock(clock), .reset(reset), .enable(active), .ref_clk_sample(bus.ref_clk_sample),
        .done(done), .pass(pass), .count(count)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= WAIT_LOCK;
            lk_m <= 1'b0;
            lk_s <= 1'b0;
            stab <= '0;
            bus.rst_out <= 1'b1;
            bus.ready <= 1'b0;
            bus.freq_ok <= 1'b0;
            bus.freq_count <= '0;
            bus.lock_lost <= 1'b0;
            bus.lock_loss_count <= '0;
        end else begin
            lk_m <= bus.pll_locked;
            lk_s <= lk_m;
            if (state == WAIT_LOCK) begin
                bus.rst_out <= 1'b1;
                bus.ready <= 1'b0;
                if (lk_s) begin
                    state <= STABLE;
                    stab <= '0;
                end
            // lock loss outranks a coinciding window close, which is discarded
            end else if (!lk_s) begin
                state <= WAIT_LOCK;
                bus.rst_out <= 1'b1;
                bus.ready <= 1'b0;
                bus.lock_lost <= 1'b1;
                bus.lock_loss_count <= bus.lock_loss_count + 8'(bus.lock_loss_count != LOSS_MAX);
            end else if (state == STABLE) begin
                stab <= stab + 1'b1;
                if (stab == STAB_LAST) state <= MEASURE;
            end else if (done) begin
                state <= pass ? RUN : FAULT;
                bus.rst_out <= !pass;
                bus.ready <= pass;
                bus.freq_ok <= pass;
                bus.freq_count <= count;
            end
        end
    end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: randomized scenarios checked against window arithmetic derived from
// the reference period (count = cycles spanned by REF_WINDOW reference periods).
`timescale 1ns/1ps
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;
    localparam int SC = 16, WIN = 16, RAT = 18, TOLR = 4;
    localparam int NOMINAL = RAT * WIN;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0, errors = 0;
    int half = 9, ext = 0, ext_at = -1, toggles = 0, ph = 0, losses = 0;

    pll_lock_supervisor_if #(.CNT_W(16)) bus ();
    pll_lock_supervisor #(
        .STABLE_CYCLES(SC), .REF_WINDOW(WIN), .RATIO(RAT), .TOL(TOLR), .CNT_W(16)
    ) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // reference generator: half-period 'half' core cycles, one phase optionally stretched by 'ext'
    initial begin
        bus.ref_clk_sample = 1'b0;
        forever begin
            @(negedge clock);
            if (half == 0) begin
                bus.ref_clk_sample = 1'b0;
                ph = 0;
            end else begin
                ph++;
                if (ph >= half + (toggles == ext_at ? ext : 0)) begin
                    bus.ref_clk_sample = ~bus.ref_clk_sample;
                    ph = 0;
                    toggles++;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int win_count(input int h, input int e);
        return 2 * h * WIN + e;
    endfunction

    function automatic bit win_ok(input int c);
        int d;
        d = c > NOMINAL ? c - NOMINAL : NOMINAL - c;
        return d <= TOLR && c < 65535;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.pll_locked = 1'b0;
        cyc(2);
        reset = 1'b0;
        losses = 0;
    endtask

    task automatic wait_ready(input int bound, output int n, output bit held);
        n = 0;
        held = 1'b1;
        while (bus.ready !== 1'b1 && n < bound) begin
            if (bus.rst_out !== 1'b1) held = 1'b0;
            @(negedge clock);
            n++;
        end
    endtask

    task automatic wait_done(output bit ok);
        int n;
        n = 0;
        while (dut.u_meter.done !== 1'b1 && n < 70000) begin
            @(negedge clock);
            n++;
        end
        ok = dut.u_meter.done === 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pll_locked = 1'b1;
        half = 9;
        cyc(3);
        checks++; if ({bus.rst_out, bus.ready, bus.freq_ok, bus.lock_lost} !== 4'b1000) begin errors++; $display("FAIL reset_flags: got %b want 1000", {bus.rst_out, bus.ready, bus.freq_ok, bus.lock_lost}); end
        checks++; if (bus.freq_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.freq_count); end
        checks++; if (bus.lock_loss_count !== 8'd0) begin errors++; $display("FAIL reset_llc: got %0d want 0", bus.lock_loss_count); end
        checks++; if (dut.state !== WAIT_LOCK) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state, WAIT_LOCK); end
    endtask

    task automatic test_clean_lock();
        int n;
        bit held;
        half = 9;
        do_reset();
        cyc(10);
        bus.pll_locked = 1'b1;
        wait_ready(400, n, held);
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL clean_ready: got %b want 1 after %0d cycles", bus.ready, n); end
        checks++; if (!held) begin errors++; $display("FAIL clean_rst_held: rst_out dropped before release, want 1"); end
        checks++; if (n < 305 || n > 330) begin errors++; $display("FAIL clean_latency: got %0d want 305..330", n); end
        checks++; if (bus.freq_count !== 16'(win_count(9, 0))) begin errors++; $display("FAIL clean_count: got %0d want %0d", bus.freq_count, win_count(9, 0)); end
        checks++; if ({bus.freq_ok, bus.rst_out, bus.lock_lost} !== {win_ok(win_count(9, 0)), 2'b00}) begin errors++; $display("FAIL clean_flags: got %b want 100", {bus.freq_ok, bus.rst_out, bus.lock_lost}); end
    endtask

    task automatic test_bounce();
        int n;
        bit saw_stable, saw_wait;
        half = 9;
        do_reset();
        cyc(5);
        bus.pll_locked = 1'b1;
        cyc(7);
        saw_stable = dut.state === STABLE;
        cyc(1);
        bus.pll_locked = 1'b0;
        cyc(1);
        bus.pll_locked = 1'b1;
        losses++;
        n = 0;
        saw_wait = 1'b0;
        while (bus.ready !== 1'b1 && n < 400) begin
            if (n < 6 && dut.state === WAIT_LOCK) saw_wait = 1'b1;
            @(negedge clock);
            n++;
        end
        checks++; if (!saw_stable) begin errors++; $display("FAIL bounce_in_stable: got state %0d want %0d", dut.state, STABLE); end
        checks++; if (!saw_wait) begin errors++; $display("FAIL bounce_wait_lock: got no WAIT_LOCK, want WAIT_LOCK after glitch"); end
        checks++; if (bus.ready !== 1'b1 || n < 305 || n > 330) begin errors++; $display("FAIL bounce_release: got ready=%b at %0d want 1 at 305..330", bus.ready, n); end
        checks++; if (bus.lock_lost !== 1'b1 || bus.lock_loss_count !== 8'(losses)) begin errors++; $display("FAIL bounce_diag: got lost=%b cnt=%0d want 1/%0d", bus.lock_lost, bus.lock_loss_count, losses); end
    endtask

    task automatic test_wrong_freq();
        int n;
        bit held;
        half = 10;
        do_reset();
        cyc(3);
        bus.pll_locked = 1'b1;
        n = 0;
        while (dut.state !== FAULT && n < 500) begin
            @(negedge clock);
            n++;
        end
        checks++; if (dut.state !== FAULT) begin errors++; $display("FAIL wrong_state: got %0d want %0d", dut.state, FAULT); end
        checks++; if (bus.freq_count !== 16'(win_count(10, 0))) begin errors++; $display("FAIL wrong_count: got %0d want %0d", bus.freq_count, win_count(10, 0)); end
        checks++; if ({bus.freq_ok, bus.rst_out, bus.ready} !== {win_ok(win_count(10, 0)), 2'b10}) begin errors++; $display("FAIL wrong_flags: got %b want 010", {bus.freq_ok, bus.rst_out, bus.ready}); end
        half = 9;
        wait_ready(1000, n, held);
        checks++; if (bus.ready !== 1'b1 || bus.rst_out !== 1'b0) begin errors++; $display("FAIL recover_run: got ready=%b rst=%b want 1/0", bus.ready, bus.rst_out); end
        checks++; if (bus.freq_count !== 16'(win_count(9, 0)) || bus.freq_ok !== 1'b1) begin errors++; $display("FAIL recover_count: got %0d ok=%b want %0d ok=1", bus.freq_count, bus.freq_ok, win_count(9, 0)); end
    endtask

    task automatic test_tolerance();
        int e, c;
        bit ok1, ok2;
        int evals[6];
        evals = '{4, -4, 5, -5, 0, 0};
        evals[4] = int'($urandom_range(11, 0)) - 5;
        evals[5] = int'($urandom_range(11, 0)) - 5;
        foreach (evals[i]) begin
            e = evals[i];
            c = win_count(9, e);
            wait_done(ok1);
            ext = e;
            ext_at = toggles;
            wait_done(ok2);
            checks++; if (!ok1 || !ok2) begin errors++; $display("FAIL tol_timeout: got no window close, want close (ext %0d)", e); end
            checks++; if (bus.freq_count !== 16'(c) || bus.freq_ok !== win_ok(c)) begin errors++; $display("FAIL tol_window: got %0d ok=%b want %0d ok=%b", bus.freq_count, bus.freq_ok, c, win_ok(c)); end
            checks++; if (bus.ready !== win_ok(c) || bus.rst_out !== !win_ok(c)) begin errors++; $display("FAIL tol_state: got ready=%b rst=%b want %b/%b", bus.ready, bus.rst_out, win_ok(c), !win_ok(c)); end
        end
    endtask

    task automatic test_random_freq();
        int h, n, c;
        for (int k = 0; k < 3; k++) begin
            h = int'($urandom_range(11, 7));
            c = win_count(h, 0);
            half = h;
            do_reset();
            cyc(int'($urandom_range(20, 1)));
            bus.pll_locked = 1'b1;
            n = 0;
            while (bus.freq_count === 16'd0 && n < 500) begin
                @(negedge clock);
                n++;
            end
            checks++; if (bus.freq_count !== 16'(c) || bus.freq_ok !== win_ok(c)) begin errors++; $display("FAIL rand_window: got %0d ok=%b want %0d ok=%b", bus.freq_count, bus.freq_ok, c, win_ok(c)); end
            checks++; if (bus.ready !== win_ok(c) || bus.rst_out !== !win_ok(c)) begin errors++; $display("FAIL rand_state: got ready=%b rst=%b want %b/%b", bus.ready, bus.rst_out, win_ok(c), !win_ok(c)); end
        end
    endtask

    task automatic test_loss_coincident();
        int n;
        bit held, ok;
        half = 9;
        do_reset();
        cyc(4);
        bus.pll_locked = 1'b1;
        wait_ready(400, n, held);
        wait_done(ok);
        // stretch the next window to 290 so a wrongly accepted close would be visible
        ext = 2;
        ext_at = toggles;
        cyc(287);
        bus.pll_locked = 1'b0;
        losses++;
        cyc(2);
        checks++; if (dut.u_meter.done !== 1'b1 || dut.lk_s !== 1'b0 || dut.state !== RUN) begin errors++; $display("FAIL coinc_setup: got done=%b lk_s=%b state=%0d want 1/0/%0d", dut.u_meter.done, dut.lk_s, dut.state, RUN); end
        cyc(1);
        checks++; if (dut.state !== WAIT_LOCK) begin errors++; $display("FAIL coinc_state: got %0d want %0d", dut.state, WAIT_LOCK); end
        checks++; if ({bus.rst_out, bus.ready, bus.lock_lost} !== 3'b101 || bus.lock_loss_count !== 8'(losses)) begin errors++; $display("FAIL coinc_diag: got %b cnt=%0d want 101 cnt=%0d", {bus.rst_out, bus.ready, bus.lock_lost}, bus.lock_loss_count, losses); end
        checks++; if (bus.freq_count !== 16'(win_count(9, 0)) || bus.freq_ok !== 1'b1) begin errors++; $display("FAIL coinc_hold: got %0d ok=%b want %0d ok=1", bus.freq_count, bus.freq_ok, win_count(9, 0)); end
    endtask

    task automatic test_mid_reset();
        int n;
        bit held;
        half = 9;
        do_reset();
        cyc(2);
        bus.pll_locked = 1'b1;
        wait_ready(400, n, held);
        repeat (3) begin
            bus.pll_locked = 1'b0;
            cyc(3);
            losses++;
            bus.pll_locked = 1'b1;
            wait_ready(400, n, held);
        end
        checks++; if (bus.ready !== 1'b1 || bus.lock_loss_count !== 8'(losses)) begin errors++; $display("FAIL midrst_pre: got ready=%b cnt=%0d want 1/%0d", bus.ready, bus.lock_loss_count, losses); end
        reset = 1'b1;
        cyc(1);
        checks++; if ({bus.rst_out, bus.ready, bus.freq_ok, bus.lock_lost} !== 4'b1000) begin errors++; $display("FAIL midrst_flags: got %b want 1000", {bus.rst_out, bus.ready, bus.freq_ok, bus.lock_lost}); end
        checks++; if (bus.freq_count !== 16'd0 || bus.lock_loss_count !== 8'd0) begin errors++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", bus.freq_count, bus.lock_loss_count); end
        checks++; if (dut.state !== WAIT_LOCK) begin errors++; $display("FAIL midrst_state: got %0d want %0d", dut.state, WAIT_LOCK); end
        reset = 1'b0;
    endtask

    task automatic test_missing_ref();
        int n;
        bit held;
        half = 9;
        do_reset();
        cyc(3);
        bus.pll_locked = 1'b1;
        wait_ready(400, n, held);
        half = 0;
        n = 0;
        while (bus.freq_count !== 16'hffff && n < 70000) begin
            @(negedge clock);
            n++;
        end
        checks++; if (bus.freq_count !== 16'd65535 || bus.freq_ok !== win_ok(65535)) begin errors++; $display("FAIL missing_count: got %0d ok=%b want 65535 ok=0", bus.freq_count, bus.freq_ok); end
        checks++; if (dut.state !== FAULT || bus.rst_out !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL missing_state: got %0d rst=%b rdy=%b want %0d/1/0", dut.state, bus.rst_out, bus.ready, FAULT); end
        half = 9;
        wait_ready(1000, n, held);
        checks++; if (bus.ready !== 1'b1 || bus.freq_count !== 16'(win_count(9, 0))) begin errors++; $display("FAIL missing_recover: got ready=%b count=%0d want 1/%0d", bus.ready, bus.freq_count, win_count(9, 0)); end
    endtask

    initial begin
        bus.pll_locked = 1'b0;
        test_reset();
        test_clean_lock();
        test_bounce();
        test_wrong_freq();
        test_tolerance();
        test_random_freq();
        test_loss_coincident();
        test_mid_reset();
        test_missing_ref();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
